// File: rtl/booth_arbiter.sv
// rtl/booth_arbiter.sv - round-robin arbiter sharing one multiplier between two requesters
// Owner and operands are held from GRANT until the operation ends in DONE or ABORT.
module booth_arbiter #(
    parameter int TIMEOUT = 40,
    parameter int GUARD   = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] res0,
    output logic [15:0] res1,
    output logic        busy,
    output logic        mul_bgn,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_stop,
    input  logic [15:0] mul_obus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        DONE,
        ABORT
    } state_t;

    state_t        state, state_nx;
    logic          owner, owner_nx;
    logic          last, last_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    opa, opb;
    logic [7:0]    sel_a, sel_b;

    assign sel_a = owner ? a1 : a0;
    assign sel_b = owner ? b1 : b0;

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                // last holds the previously served requester; ties go to the other one
                if (req0 && req1) begin
                    owner_nx = ~last;
                    state_nx = GRANT;
                end else if (req0) begin
                    owner_nx = 1'b0;
                    state_nx = GRANT;
                end else if (req1) begin
                    owner_nx = 1'b1;
                    state_nx = GRANT;
                end
            end
            GRANT: state_nx = START;
            START: state_nx = WAIT;
            WAIT: begin
                cnt_nx = cnt + 1'b1;
                if (mul_stop && (cnt >= CW'(GUARD))) begin
                    state_nx = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nx = ABORT;
                end
            end
            DONE, ABORT: begin
                last_nx  = owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            res0  <= '0;
            res1  <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
            if (state == GRANT) begin
                opa <= sel_a;
                opb <= sel_b;
            end
            if (state == WAIT && state_nx == DONE) begin
                if (owner) res1 <= mul_obus;
                else       res0 <= mul_obus;
            end
        end
    end

    // GRANT drives the operands being latched so the bus never changes across GRANT..WAIT
    assign mul_a   = (state == IDLE) ? 8'd0 : (state == GRANT) ? sel_a : opa;
    assign mul_b   = (state == IDLE) ? 8'd0 : (state == GRANT) ? sel_b : opb;
    assign busy    = (state != IDLE);
    assign mul_bgn = (state == START);
    assign done0   = (state == DONE)  && !owner;
    assign done1   = (state == DONE)  &&  owner;
    assign err0    = (state == ABORT) && !owner;
    assign err1    = (state == ABORT) &&  owner;

endmodule

// File: tb/tb_booth_arbiter.sv
// tb/tb_booth_arbiter.sv - directed self-checking bench for booth_arbiter
// A behavioural signed multiplier answers mul_bgn with a programmable stop behaviour.
module tb_booth_arbiter;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        done0, done1, err0, err1, busy, mul_bgn, mul_stop;
    logic [15:0] res0, res1, mul_obus;
    logic [7:0]  mul_a, mul_b;

    int checks = 0;
    int errors = 0;

    // 0: stop after lat cycles of WAIT, 1: stop held high, 2: stop held low
    int stop_mode = 0;
    int lat = 3;
    int mcnt = 1000;

    int cyc = 0, g_cyc = 0, p_cyc = 0;
    int n_bgn = 0, n_d0 = 0, n_d1 = 0, n_e0 = 0, n_e1 = 0;
    logic       busy_d = 1'b0;
    logic       last_id = 1'b0;
    logic [7:0] bgn_a = '0, bgn_b = '0;

    always #5 clk = ~clk;

    booth_arbiter dut (
        .clk(clk), .rst_b(rst_b),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .res0(res0), .res1(res1), .busy(busy),
        .mul_bgn(mul_bgn), .mul_a(mul_a), .mul_b(mul_b),
        .mul_stop(mul_stop), .mul_obus(mul_obus)
    );

    always @(posedge clk) begin
        if (mul_bgn) mcnt <= 0;
        else if (mcnt < 1000) mcnt <= mcnt + 1;
    end

    assign mul_stop = (stop_mode == 1) ? 1'b1 :
                      (stop_mode == 2) ? 1'b0 : (mcnt >= lat);
    assign mul_obus = 16'($signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b}));

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        busy_d <= busy;
        if (busy && !busy_d) g_cyc <= cyc;
        if (mul_bgn) begin
            n_bgn <= n_bgn + 1;
            bgn_a <= mul_a;
            bgn_b <= mul_b;
        end
        if (done0) n_d0 <= n_d0 + 1;
        if (done1) n_d1 <= n_d1 + 1;
        if (err0)  n_e0 <= n_e0 + 1;
        if (err1)  n_e1 <= n_e1 + 1;
        if (done0 || done1 || err0 || err1) begin
            p_cyc   <= cyc;
            last_id <= done1 || err1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requesters drop their request on their own done/err pulse
    task automatic wait_pulses(input string tag, input int target, input int budget);
        int  seen;
        bit  ok;
        seen = 0;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done0 || err0) begin req0 = 1'b0; seen++; end
            if (done1 || err1) begin req1 = 1'b0; seen++; end
            if (seen >= target && !busy) begin ok = 1'b1; break; end
        end
        #1;
        chk({tag, "_complete"}, 32'(ok), 32'd1);
    endtask

    int bg, d0, d1, e0, e1;

    task automatic snap();
        bg = n_bgn; d0 = n_d0; d1 = n_d1; e0 = n_e0; e1 = n_e1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res0", 32'(res0), 0);
        chk("rst_res1", 32'(res1), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_bgn", 32'(mul_bgn), 0);
        chk("rst_pulses", 32'({done0, done1, err0, err1}), 0);
        rst_b = 1'b0;
        @(negedge clk);

        // single request 7*6
        snap();
        a0 = 8'd7; b0 = 8'd6; req0 = 1'b1;
        wait_pulses("single", 1, 100);
        chk("single_bgn", 32'(n_bgn - bg), 1);
        chk("single_mul_a", 32'(bgn_a), 7);
        chk("single_mul_b", 32'(bgn_b), 6);
        chk("single_done0", 32'(n_d0 - d0), 1);
        chk("single_done1", 32'(n_d1 - d1), 0);
        chk("single_res0", 32'(res0), 32'd42);
        chk("single_busy", 32'(busy), 0);

        // signed -3*5 on requester 1
        snap();
        a1 = 8'hFD; b1 = 8'd5; req1 = 1'b1;
        wait_pulses("signed", 1, 100);
        chk("signed_res1", 32'(res1), 32'hFFF1);
        chk("signed_done1", 32'(n_d1 - d1), 1);
        chk("signed_done0", 32'(n_d0 - d0), 0);
        chk("signed_res0_kept", 32'(res0), 32'd42);

        // contention right after a reset: requester 0 first
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        snap();
        a0 = 8'd3; b0 = 8'd4; a1 = 8'd2; b1 = 8'hFE;
        req0 = 1'b1; req1 = 1'b1;
        wait_pulses("cont_first", 1, 100);
        chk("cont_first_id", 32'(last_id), 0);
        wait_pulses("cont_second", 1, 100);
        chk("cont_second_id", 32'(last_id), 1);
        chk("cont_bgn", 32'(n_bgn - bg), 2);
        chk("cont_res0", 32'(res0), 32'h000C);
        chk("cont_res1", 32'(res1), 32'hFFFC);

        // stop held high: capture at WAIT count 2, done five cycles after GRANT
        snap();
        stop_mode = 1;
        a0 = 8'd9; b0 = 8'd9; req0 = 1'b1;
        wait_pulses("stale", 1, 100);
        chk("stale_latency", 32'(p_cyc - g_cyc), 5);
        chk("stale_res0", 32'(res0), 32'd81);
        chk("stale_done0", 32'(n_d0 - d0), 1);

        // stop held low: abort after 40 WAIT cycles
        snap();
        stop_mode = 2;
        a0 = 8'd3; b0 = 8'd3; req0 = 1'b1;
        wait_pulses("tmo", 1, 200);
        chk("tmo_err0", 32'(n_e0 - e0), 1);
        chk("tmo_done0", 32'(n_d0 - d0), 0);
        chk("tmo_latency", 32'(p_cyc - g_cyc), 42);
        chk("tmo_res0_kept", 32'(res0), 32'd81);

        // asynchronous reset in the middle of WAIT
        snap();
        a0 = 8'd4; b0 = 8'd4; req0 = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_in_wait", 32'(busy), 1);
        #2;
        rst_b = 1'b1;
        req0  = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_mul_a", 32'(mul_a), 0);
        chk("mid_mul_b", 32'(mul_b), 0);
        chk("mid_res0", 32'(res0), 0);
        chk("mid_res1", 32'(res1), 0);
        @(negedge clk);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_no_pulse", 32'((n_d0 - d0) + (n_e0 - e0)), 0);
        stop_mode = 0;
        a0 = 8'd5; b0 = 8'd5; req0 = 1'b1;
        wait_pulses("fresh", 1, 100);
        chk("fresh_res0", 32'(res0), 32'd25);
        chk("fresh_done0", 32'(n_d0 - d0), 1);

        // requester 1 withdraws while requester 0 is in WAIT
        snap();
        lat = 6;
        a0 = 8'd2; b0 = 8'd3; a1 = 8'd9; b1 = 8'd9; req0 = 1'b1;
        repeat (4) @(negedge clk);
        req1 = 1'b1;
        repeat (2) @(negedge clk);
        req1 = 1'b0;
        wait_pulses("withdraw", 1, 100);
        repeat (3) @(negedge clk);
        #1;
        chk("withdraw_res0", 32'(res0), 32'd6);
        chk("withdraw_bgn", 32'(n_bgn - bg), 1);
        chk("withdraw_done1", 32'(n_d1 - d1), 0);
        chk("withdraw_res1", 32'(res1), 0);
        chk("withdraw_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
